// File: rtl/cpu_control_fsm.sv
// cpu_control_fsm: multi-cycle fetch/decode/execute/memory/writeback sequencer for the AVR-subset CPU
//   clk, reset            : rising-edge clock, asynchronous active-low reset
//   opcode_type           : one-hot instruction type from decode_unit (bit 0 = unknown)
//   opcode_group          : group bits from decode_unit {store, memory, register, alu}
//   halt                  : request to stop at the next instruction boundary
//   imem_ack, dmem_ack    : memory handshake acks (same-cycle ack allowed)
//   imem_req, ir_load     : instruction fetch request and instruction register load
//   alu_enable, sreg_we   : ALU evaluate and status register write
//   addr_indirect         : data address from Y pointer instead of the immediate field
//   dmem_req, dmem_we     : data memory request and write qualifier
//   rf_we, rf_src         : register file write and source (0 ALU, 1 imd, 2 rr, 3 memory)
//   pc_inc                : retire pulse
//   state, trap, retired  : state encoding, sticky fault, retired-instruction count
`ifndef OPCODE_COUNT
`define OPCODE_COUNT 13
`endif
`ifndef GROUP_COUNT
`define GROUP_COUNT 4
`endif
module cpu_control_fsm #(
   parameter int RETIRED_WIDTH = 16,
   parameter int MEM_TIMEOUT   = 15,
   parameter int TO_WIDTH      = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [`OPCODE_COUNT-1:0] opcode_type,
   input  logic [`GROUP_COUNT-1:0]  opcode_group,
   input  logic                     halt,
   input  logic                     imem_ack,
   input  logic                     dmem_ack,
   output logic                     imem_req,
   output logic                     ir_load,
   output logic                     alu_enable,
   output logic                     sreg_we,
   output logic                     addr_indirect,
   output logic                     dmem_req,
   output logic                     dmem_we,
   output logic                     rf_we,
   output logic [1:0]               rf_src,
   output logic                     pc_inc,
   output logic [2:0]               state,
   output logic                     trap,
   output logic [RETIRED_WIDTH-1:0] retired
);
   localparam int T_UNKNOWN = 0;
   localparam int T_NOP     = 1;
   localparam int T_MOV     = 7;
   localparam int T_LDI     = 8;
   localparam int T_LD_Y    = 11;
   localparam int T_ST_Y    = 12;
   localparam int G_ALU     = 0;
   localparam int G_MEM     = 2;
   localparam int G_STORE   = 3;
   typedef enum logic [2:0] {
      S_RESET = 3'd0, S_IF = 3'd1, S_ID = 3'd2, S_EX = 3'd3,
      S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6, S_TRAP = 3'd7
   } state_t;
   state_t st, nxt, done;
   logic alu_q, mem_q, store_q, ind_q, ldi_q, mov_q;
   logic alu_n, mem_n, store_n, ind_n, ldi_n, mov_n;
   logic [TO_WIDTH-1:0] to_cnt;
   logic legal, waiting, timed_out;
   // decode flags are captured in S_ID; the *_n copies let the registered strobes
   // for the state entered from S_ID see the decode result on the same edge
   assign alu_n   = st == S_ID ? opcode_group[G_ALU] : alu_q;
   assign mem_n   = st == S_ID ? opcode_group[G_MEM] : mem_q;
   assign store_n = st == S_ID ? opcode_group[G_STORE] : store_q;
   assign ind_n   = st == S_ID ? opcode_type[T_LD_Y] | opcode_type[T_ST_Y] : ind_q;
   assign ldi_n   = st == S_ID ? opcode_type[T_LDI] : ldi_q;
   assign mov_n   = st == S_ID ? opcode_type[T_MOV] : mov_q;
   // an all-zero type vector is treated like the explicit unknown type
   assign legal     = !opcode_type[T_UNKNOWN] && |opcode_type[`OPCODE_COUNT-1:1];
   assign waiting   = (st == S_IF && !imem_ack) || (st == S_MEM && !dmem_ack);
   // trap on the cycle the wait count would reach MEM_TIMEOUT; an ack that cycle wins
   assign timed_out = waiting && to_cnt == TO_WIDTH'(MEM_TIMEOUT - 1);
   assign done      = halt ? S_HALT : S_IF;
   assign ir_load   = st == S_IF && imem_ack;
   assign pc_inc    = (st == S_ID && legal && opcode_type[T_NOP]) || st == S_WB ||
                      (st == S_MEM && dmem_ack && store_q);
   assign state     = st;
   always_comb begin
      nxt = st;
      case (st)
         S_RESET: nxt = S_IF;
         S_IF:    nxt = imem_ack ? S_ID : timed_out ? S_TRAP : S_IF;
         S_ID:    nxt = !legal ? S_TRAP : opcode_type[T_NOP] ? done :
                        |opcode_group[G_MEM:G_ALU] ? S_EX : S_TRAP;
         S_EX:    nxt = mem_q ? S_MEM : S_WB;
         S_MEM:   nxt = dmem_ack ? (store_q ? done : S_WB) : timed_out ? S_TRAP : S_MEM;
         S_WB:    nxt = done;
         S_HALT:  nxt = halt ? S_HALT : S_IF;
         default: nxt = S_TRAP;
      endcase
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         st            <= S_RESET;
         alu_q         <= 1'b0;
         mem_q         <= 1'b0;
         store_q       <= 1'b0;
         ind_q         <= 1'b0;
         ldi_q         <= 1'b0;
         mov_q         <= 1'b0;
         to_cnt        <= '0;
         retired       <= '0;
         imem_req      <= 1'b0;
         alu_enable    <= 1'b0;
         addr_indirect <= 1'b0;
         dmem_req      <= 1'b0;
         dmem_we       <= 1'b0;
         rf_we         <= 1'b0;
         sreg_we       <= 1'b0;
         rf_src        <= 2'd0;
         trap          <= 1'b0;
      end else begin
         st            <= nxt;
         alu_q         <= alu_n;
         mem_q         <= mem_n;
         store_q       <= store_n;
         ind_q         <= ind_n;
         ldi_q         <= ldi_n;
         mov_q         <= mov_n;
         to_cnt        <= (waiting && nxt == st) ? to_cnt + TO_WIDTH'(1) : '0;
         retired       <= retired + RETIRED_WIDTH'(pc_inc);
         imem_req      <= nxt == S_IF;
         alu_enable    <= nxt == S_EX && alu_n;
         addr_indirect <= (nxt == S_EX || nxt == S_MEM) && ind_n;
         dmem_req      <= nxt == S_MEM;
         dmem_we       <= nxt == S_MEM && store_n;
         rf_we         <= nxt == S_WB;
         sreg_we       <= nxt == S_WB && alu_n;
         rf_src        <= nxt != S_WB ? 2'd0 : mem_n ? 2'd3 : mov_n ? 2'd2 : ldi_n ? 2'd1 : 2'd0;
         trap          <= nxt == S_TRAP;
      end
endmodule

// File: tb/tb_cpu_control_fsm.sv
// tb_cpu_control_fsm: directed scoreboard bench for cpu_control_fsm
module tb_cpu_control_fsm;
   localparam logic [2:0] S_RESET = 3'd0, S_IF = 3'd1, S_ID = 3'd2, S_EX = 3'd3,
                          S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6, S_TRAP = 3'd7;
   localparam logic [11:0] IMR = 12'h800, IRL = 12'h400, ALU = 12'h200, SRW = 12'h100,
                           AI = 12'h080, DR = 12'h040, DW = 12'h020, RWE = 12'h010,
                           PCI = 12'h008, TRP = 12'h004;
   localparam int T_UNKNOWN = 0, T_NOP = 1, T_ADD = 2, T_MOV = 7, T_LDI = 8,
                  T_LDS = 9, T_STS = 10, T_LD_Y = 11;
   logic clk = 1'b0;
   logic reset, halt, imem_ack, dmem_ack;
   logic [12:0] opcode_type;
   logic [3:0] opcode_group;
   logic imem_req, ir_load, alu_enable, sreg_we, addr_indirect, dmem_req, dmem_we, rf_we, pc_inc, trap;
   logic [1:0] rf_src;
   logic [2:0] state;
   logic [7:0] retired;
   logic [14:0] obs;
   string tag_q[$];
   logic [14:0] exp_q[$];
   int ntests = 0, nfail = 0, exp_ret = 0;
   cpu_control_fsm #(.RETIRED_WIDTH(8), .MEM_TIMEOUT(15), .TO_WIDTH(4)) dut (
      .clk(clk), .reset(reset), .opcode_type(opcode_type), .opcode_group(opcode_group),
      .halt(halt), .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req),
      .ir_load(ir_load), .alu_enable(alu_enable), .sreg_we(sreg_we),
      .addr_indirect(addr_indirect), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .rf_we(rf_we), .rf_src(rf_src), .pc_inc(pc_inc), .state(state), .trap(trap),
      .retired(retired)
   );
   assign obs = {state, imem_req, ir_load, alu_enable, sreg_we, addr_indirect, dmem_req,
                 dmem_we, rf_we, pc_inc, trap, rf_src};
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [14:0] o, input logic [14:0] e);
      ntests++;
      assert (o === e) else begin
         nfail++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask
   task automatic push(input string tag, input logic [2:0] s, input logic [11:0] f);
      tag_q.push_back(tag);
      exp_q.push_back({s, f});
      if (f[3]) exp_ret++;
   endtask
   task automatic cyc();
      @(negedge clk);
      if (exp_q.size() == 0) begin
         ntests++;
         nfail++;
         $display("FAIL sb_underflow observed=%h expected=<none>", obs);
      end else chk(tag_q.pop_front(), obs, exp_q.pop_front());
      @(posedge clk);
      #1;
   endtask
   task automatic drain();
      while (exp_q.size() != 0) cyc();
   endtask
   task automatic ret(input string tag);
      chk(tag, 15'(retired), 15'(exp_ret[7:0]));
   endtask
   task automatic set_op(input int t, input logic [3:0] g);
      opcode_type = 13'd1 << t;
      opcode_group = g;
   endtask
   task automatic nop();
      push("nop_if", S_IF, IMR | IRL);
      push("nop_id", S_ID, PCI);
   endtask
   task automatic do_reset(input string tag);
      reset = 1'b0;
      exp_ret = 0;
      push(tag, S_RESET, 12'h0);
      cyc();
      ret({tag, "_ret"});
      reset = 1'b1;
      push({tag, "_rel"}, S_RESET, 12'h0);
   endtask
   initial begin
      reset = 1'b1; halt = 1'b0; imem_ack = 1'b1; dmem_ack = 1'b1;
      set_op(T_NOP, 4'b0000);
      #2 reset = 1'b0;
      @(posedge clk);
      #1;
      do_reset("rst");
      set_op(T_ADD, 4'b0001);
      push("add_if", S_IF, IMR | IRL);
      push("add_id", S_ID, 12'h0);
      push("add_ex", S_EX, ALU);
      push("add_wb", S_WB, SRW | RWE | PCI);
      drain();
      ret("add_ret");
      set_op(T_LDS, 4'b0100);
      dmem_ack = 1'b0;
      push("lds_if", S_IF, IMR | IRL);
      push("lds_id", S_ID, 12'h0);
      push("lds_ex", S_EX, 12'h0);
      for (int i = 0; i < 4; i++) push("lds_mem", S_MEM, DR);
      push("lds_wb", S_WB, RWE | PCI | 12'h003);
      repeat (6) cyc();
      dmem_ack = 1'b1;
      drain();
      ret("lds_ret");
      set_op(T_STS, 4'b1100);
      push("sts_if", S_IF, IMR | IRL);
      push("sts_id", S_ID, 12'h0);
      push("sts_ex", S_EX, 12'h0);
      push("sts_mem", S_MEM, DR | DW | PCI);
      drain();
      ret("sts_ret");
      set_op(T_LD_Y, 4'b0100);
      push("ldy_if", S_IF, IMR | IRL);
      push("ldy_id", S_ID, 12'h0);
      push("ldy_ex", S_EX, AI);
      push("ldy_mem", S_MEM, AI | DR);
      push("ldy_wb", S_WB, RWE | PCI | 12'h003);
      drain();
      set_op(T_LDI, 4'b0010);
      push("ldi_if", S_IF, IMR | IRL);
      push("ldi_id", S_ID, 12'h0);
      push("ldi_ex", S_EX, 12'h0);
      push("ldi_wb", S_WB, RWE | PCI | 12'h001);
      drain();
      set_op(T_MOV, 4'b0010);
      push("mov_if", S_IF, IMR | IRL);
      push("mov_id", S_ID, 12'h0);
      push("mov_ex", S_EX, 12'h0);
      push("mov_wb", S_WB, RWE | PCI | 12'h002);
      drain();
      ret("mov_ret");
      set_op(T_ADD, 4'b0001);
      push("hadd_if", S_IF, IMR | IRL);
      push("hadd_id", S_ID, 12'h0);
      repeat (2) cyc();
      halt = 1'b1;
      push("hadd_ex", S_EX, ALU);
      push("hadd_wb", S_WB, SRW | RWE | PCI);
      push("halt_1", S_HALT, 12'h0);
      repeat (3) cyc();
      halt = 1'b0;
      set_op(T_NOP, 4'b0000);
      push("halt_2", S_HALT, 12'h0);
      repeat (3) nop();
      drain();
      ret("nop_ret");
      imem_ack = 1'b0;
      for (int i = 0; i < 14; i++) push("late_wait", S_IF, IMR);
      push("late_ack", S_IF, IMR | IRL);
      push("late_id", S_ID, PCI);
      repeat (14) cyc();
      imem_ack = 1'b1;
      drain();
      ret("late_ret");
      imem_ack = 1'b0;
      for (int i = 0; i < 15; i++) push("ito_wait", S_IF, IMR);
      push("ito_trap", S_TRAP, TRP);
      push("ito_hold", S_TRAP, TRP);
      drain();
      imem_ack = 1'b1;
      do_reset("rst_trap");
      set_op(T_UNKNOWN, 4'b0000);
      push("unk_if", S_IF, IMR | IRL);
      push("unk_id", S_ID, 12'h0);
      push("unk_trap", S_TRAP, TRP);
      drain();
      do_reset("rst_unk");
      set_op(T_NOP, 4'b0000);
      nop();
      drain();
      set_op(T_LDS, 4'b0100);
      dmem_ack = 1'b0;
      push("mid_if", S_IF, IMR | IRL);
      push("mid_id", S_ID, 12'h0);
      push("mid_ex", S_EX, 12'h0);
      push("mid_mem", S_MEM, DR);
      drain();
      ret("mid_ret");
      do_reset("rst_mem");
      push("dto_if", S_IF, IMR | IRL);
      push("dto_id", S_ID, 12'h0);
      push("dto_ex", S_EX, 12'h0);
      for (int i = 0; i < 15; i++) push("dto_wait", S_MEM, DR);
      push("dto_trap", S_TRAP, TRP);
      drain();
      dmem_ack = 1'b1;
      do_reset("rst_dto");
      set_op(T_NOP, 4'b0000);
      for (int i = 0; i < 255; i++) nop();
      drain();
      ret("wrap_ff");
      nop();
      drain();
      ret("wrap_00");
      chk("sb_drained", 15'(exp_q.size()), 15'd0);
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end
endmodule
